// File: rtl/uart_rx_corr_2_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_corr_2_if
//  Brief    : AXI-Stream style byte channel carried by the UART receiver
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_corr_2_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_corr_2.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_corr_2
//  Brief    : LSB-first UART receiver (start, DATA_WIDTH data, one stop) with
//             AXI-Stream output, framing and overrun error pulses.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_corr_2 #(
  parameter int DATA_WIDTH = 8,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_rx_corr_2_if.master m_axis,
  input  wire logic        rxd,
  output logic             busy,
  output logic             overrun_error,
  output logic             frame_error,
  input  wire logic [15:0] prescale
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_WAITH  = 3'd4;

  logic                  r_sync1, r_rxd_s;
  logic [2:0]            r_state, w_state_nxt;
  logic [18:0]           r_cnt;
  logic [CW-1:0]         r_bitcnt;
  logic [DATA_WIDTH-1:0] r_shreg, w_payload;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid, r_ferr, r_oerr;

  logic [15:0]           w_pre;
  logic [18:0]           w_full_m1, w_half_m1;
  logic                  w_cnt_zero;
  logic                  w_ld_half, w_ld_full, w_shift, w_bit_clr;
  logic                  w_stop_ok, w_stop_bad, w_busy;

  // Prescale of zero behaves like one so the timer never wraps.
  assign w_pre      = (prescale == 16'd0) ? 16'd1 : prescale;
  assign w_full_m1  = {w_pre, 3'b000} - 19'd1;
  assign w_half_m1  = {1'b0, w_pre, 2'b00} - 19'd1;
  assign w_cnt_zero = (r_cnt == 19'd0);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxd_s <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic; all bit-level decisions wait for the timer to hit 0.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!r_rxd_s) w_state_nxt = S_START;
      S_START: if (w_cnt_zero) w_state_nxt = r_rxd_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_cnt_zero && (r_bitcnt == CW'(DATA_WIDTH - 1))) w_state_nxt = S_STOP;
      S_STOP:  if (w_cnt_zero) w_state_nxt = r_rxd_s ? S_IDLE : S_WAITH;
      S_WAITH: if (r_rxd_s) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: timer reloads, shift strobes, stop verdict and busy.
  always_comb begin
    w_ld_half  = 1'b0;
    w_ld_full  = 1'b0;
    w_shift    = 1'b0;
    w_bit_clr  = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      S_IDLE:  w_ld_half = !r_rxd_s;
      S_START: begin
        w_busy = 1'b1;
        if (w_cnt_zero && !r_rxd_s) begin
          w_ld_full = 1'b1;
          w_bit_clr = 1'b1;
        end
      end
      S_DATA: begin
        w_busy = 1'b1;
        if (w_cnt_zero) begin
          w_shift   = 1'b1;
          w_ld_full = 1'b1;
        end
      end
      S_STOP: begin
        w_busy = 1'b1;
        if (w_cnt_zero) begin
          w_stop_ok  = r_rxd_s;
          w_stop_bad = !r_rxd_s;
        end
      end
      default: ;
    endcase
  end

  // Bit timer, bit index and receive shift register (LSB arrives first).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 19'd0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
    end else begin
      if (w_ld_half)       r_cnt <= w_half_m1;
      else if (w_ld_full)  r_cnt <= w_full_m1;
      else if (!w_cnt_zero) r_cnt <= r_cnt - 19'd1;

      if (w_bit_clr)    r_bitcnt <= '0;
      else if (w_shift) r_bitcnt <= r_bitcnt + CW'(1);

      if (w_shift) r_shreg <= {r_rxd_s, r_shreg[DATA_WIDTH-1:1]};
    end
  end

  generate
    if (BIG_ENDIAN) begin : g_be
      for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
        assign w_payload[i] = r_shreg[DATA_WIDTH-1-i];
      end
    end else begin : g_le
      assign w_payload = r_shreg;
    end
  endgenerate

  // Stream output and error pulses; a new byte always wins over a pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_ferr   <= 1'b0;
      r_oerr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_bad;
      r_oerr <= w_stop_ok && r_tvalid && !m_axis.tready;
      if (w_stop_ok) begin
        r_tdata  <= w_payload;
        r_tvalid <= 1'b1;
      end else if (r_tvalid && m_axis.tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign busy          = w_busy;
  assign frame_error   = r_ferr;
  assign overrun_error = r_oerr;

endmodule
`default_nettype wire
